// File: rtl/seq_divider_if.sv
// Handshake and data bundle between a controlling FSM and seq_divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, registered results held until the next completion.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  div_if
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // Partial remainder; the (WIDTH+1)-th bit of the textbook form is always
  // zero after every step (rem < divisor), so only WIDTH bits are kept.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] rem_step_c;
  logic [WIDTH-1:0] q_step_c;

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    shifted_c = {rem_q, q_q[WIDTH-1]};
    trial_c   = shifted_c - {1'b0, d_q};
    if (!trial_c[WIDTH]) begin
      rem_step_c = trial_c[WIDTH-1:0];
      q_step_c   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step_c = shifted_c[WIDTH-1:0];
      q_step_c   = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    d_d     = d_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (div_if.start) begin
          rem_d   = '0;
          q_d     = div_if.dividend;
          d_d     = div_if.divisor;
          count_d = '0;
          if (div_if.divisor == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            quot_d  = '1;
            remo_d  = div_if.dividend;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        rem_d   = rem_step_c;
        q_d     = q_step_c;
        count_d = CNT_W'(count_q + 1'b1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = 1'b0;
          quot_d  = q_step_c;
          remo_d  = rem_step_c;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      d_q     <= d_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_if.busy        = busy_q;
  assign div_if.done        = done_q;
  assign div_if.quotient    = quot_q;
  assign div_if.remainder   = remo_q;
  assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=4: vector table plus corner sequences.
module tb_seq_divider;

  localparam int unsigned WIDTH = 4;
  localparam int          BOUND = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_divider_if #(.WIDTH(WIDTH)) dif ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dvd;
    int dvs;
    int exp_q;
    int exp_r;
    int exp_dbz;
    int exp_edges;
    int exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after acceptance until done, and cycles with busy high.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while (!dif.done && edges < BOUND) begin
      if (dif.busy) busy_cnt++;
      tick();
      edges++;
    end
    if (!dif.done) check("done_timeout", 0, 1);
  endtask

  task automatic do_op(input int dvd, input int dvs, output int edges, output int busy_cnt);
    dif.start    = 1'b1;
    dif.dividend = WIDTH'(dvd);
    dif.divisor  = WIDTH'(dvs);
    tick();
    dif.start = 1'b0;
    wait_done(edges, busy_cnt);
  endtask

  initial begin
    int edges;
    int busy_cnt;
    int done_cnt;
    int done_at;

    checks = 0;
    errors = 0;

    //            dvd dvs  q   r  dbz edges busy
    vecs[0] = '{13,  3,  4,  1, 0,  4,    4};
    vecs[1] = '{15,  1, 15,  0, 0,  4,    4};
    vecs[2] = '{ 2,  7,  0,  2, 0,  4,    4};
    vecs[3] = '{15, 15,  1,  0, 0,  4,    4};
    vecs[4] = '{ 0,  5,  0,  0, 0,  4,    4};
    vecs[5] = '{ 9,  0, 15,  9, 1,  0,    0};
    vecs[6] = '{ 8,  2,  4,  0, 0,  4,    4};

    rst_n        = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    tick();
    tick();
    check("rst_busy", int'(dif.busy), 0);
    check("rst_done", int'(dif.done), 0);
    check("rst_dbz",  int'(dif.div_by_zero), 0);
    check("rst_quot", int'(dif.quotient), 0);
    check("rst_rem",  int'(dif.remainder), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven operations.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].dvd, vecs[i].dvs, edges, busy_cnt);
      check($sformatf("v%0d_quot", i),  int'(dif.quotient), vecs[i].exp_q);
      check($sformatf("v%0d_rem", i),   int'(dif.remainder), vecs[i].exp_r);
      check($sformatf("v%0d_dbz", i),   int'(dif.div_by_zero), vecs[i].exp_dbz);
      check($sformatf("v%0d_edges", i), edges, vecs[i].exp_edges);
      check($sformatf("v%0d_busy", i),  busy_cnt, vecs[i].exp_busy);
      tick();
      check($sformatf("v%0d_done_fall", i), int'(dif.done), 0);
      check($sformatf("v%0d_quot_hold", i), int'(dif.quotient), vecs[i].exp_q);
      check($sformatf("v%0d_rem_hold", i),  int'(dif.remainder), vecs[i].exp_r);
      tick();
    end

    // Start pulses while running are ignored.
    dif.start    = 1'b1;
    dif.dividend = 4'd13;
    dif.divisor  = 4'd3;
    tick();
    done_cnt = 0;
    done_at  = -1;
    busy_cnt = int'(dif.busy);
    for (int e = 1; e <= 8; e++) begin
      dif.start    = (e == 2 || e == 4);
      dif.dividend = 4'd6;
      dif.divisor  = 4'd2;
      tick();
      if (dif.done) begin
        done_cnt++;
        if (done_at < 0) done_at = e;
      end
      if (dif.busy) busy_cnt++;
    end
    dif.start = 1'b0;
    check("busyprot_done_cnt", done_cnt, 1);
    check("busyprot_done_at", done_at, 4);
    check("busyprot_busy_cycles", busy_cnt, 4);
    check("busyprot_quot", int'(dif.quotient), 4);
    check("busyprot_rem", int'(dif.remainder), 1);
    tick();

    // Back-to-back: start held high, second op accepted on the done cycle.
    dif.start    = 1'b1;
    dif.dividend = 4'd14;
    dif.divisor  = 4'd4;
    tick();
    wait_done(edges, busy_cnt);
    check("b2b1_quot", int'(dif.quotient), 3);
    check("b2b1_rem", int'(dif.remainder), 2);
    check("b2b1_edges", edges, 4);
    dif.dividend = 4'd7;
    dif.divisor  = 4'd2;
    tick();
    dif.start = 1'b0;
    check("b2b_done_fall", int'(dif.done), 0);
    check("b2b_busy_nogap", int'(dif.busy), 1);
    check("b2b_quot_hold", int'(dif.quotient), 3);
    wait_done(edges, busy_cnt);
    check("b2b2_quot", int'(dif.quotient), 3);
    check("b2b2_rem", int'(dif.remainder), 1);
    check("b2b2_edges", edges, 4);
    tick();
    tick();

    // Reset in the middle of an operation.
    dif.start    = 1'b1;
    dif.dividend = 4'd13;
    dif.divisor  = 4'd3;
    tick();
    dif.start = 1'b0;
    tick();
    check("midrst_busy_before", int'(dif.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(dif.busy), 0);
    check("midrst_done", int'(dif.done), 0);
    check("midrst_quot", int'(dif.quotient), 0);
    check("midrst_rem", int'(dif.remainder), 0);
    check("midrst_dbz", int'(dif.div_by_zero), 0);
    tick();
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (dif.done || dif.busy) done_cnt++;
    end
    check("midrst_no_resume", done_cnt, 0);
    do_op(10, 3, edges, busy_cnt);
    check("postrst_quot", int'(dif.quotient), 3);
    check("postrst_rem", int'(dif.remainder), 1);
    check("postrst_edges", edges, 4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
